// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 keypad scanner.
// Key codes are one-hot with bit index row*NCOL+col.
package keypad_pkg;
  localparam int NCOL = 3;
  localparam int NROW = 4;
  localparam int NKEY = NCOL * NROW;

  localparam logic [NKEY-1:0] KEY_1    = 12'h001;
  localparam logic [NKEY-1:0] KEY_2    = 12'h002;
  localparam logic [NKEY-1:0] KEY_3    = 12'h004;
  localparam logic [NKEY-1:0] KEY_4    = 12'h008;
  localparam logic [NKEY-1:0] KEY_5    = 12'h010;
  localparam logic [NKEY-1:0] KEY_6    = 12'h020;
  localparam logic [NKEY-1:0] KEY_7    = 12'h040;
  localparam logic [NKEY-1:0] KEY_8    = 12'h080;
  localparam logic [NKEY-1:0] KEY_9    = 12'h100;
  localparam logic [NKEY-1:0] KEY_STAR = 12'h200;
  localparam logic [NKEY-1:0] KEY_0    = 12'h400;
  localparam logic [NKEY-1:0] KEY_HASH = 12'h800;

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} state_t;
  typedef enum logic [1:0] {C_NONE, C_ONE, C_MULTI} vec_class_t;

  function automatic vec_class_t classify(input logic [NKEY-1:0] v);
    if (v == '0)                  return C_NONE;
    else if ((v & (v - 1'b1)) == '0) return C_ONE;
    else                          return C_MULTI;
  endfunction

  // Active-low one-cold column drive for column index idx.
  function automatic logic [NCOL-1:0] col_drive(input logic [1:0] idx);
    return ~(3'b001 << idx);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read as inactive.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 3x4 matrix keypad scanner: column drive, full-frame sampling, frame-level debounce,
// one strobe per accepted press with a held one-hot code.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NROW-1:0] row_in,
  output logic [NCOL-1:0] col_out,
  output logic [NKEY-1:0] scan_data,
  output logic            valid,
  output logic            key_held
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_FRAMES);

  logic [NROW-1:0] row_sync;
  logic [SW-1:0]   slot_cnt;
  logic [1:0]      col_idx;
  logic [NKEY-1:0] frame_vec, full_vec;
  logic            slot_end, frame_end;
  state_t          state;
  logic [DW-1:0]   db_cnt;
  logic [NKEY-1:0] cand;
  vec_class_t      cls;

  sync_2ff #(.W(NROW)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (col_idx == 2'd2);

  // Frame vector with the currently driven column's rows merged in.
  for (genvar r = 0; r < NROW; r++) begin : g_row
    for (genvar c = 0; c < NCOL; c++) begin : g_col
      assign full_vec[r*NCOL+c] = frame_vec[r*NCOL+c] |
                                  ((col_idx == 2'(c)) & ~row_sync[r]);
    end
  end

  assign cls = classify(full_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt  <= '0;
      col_idx   <= '0;
      col_out   <= 3'b110;
      frame_vec <= '0;
    end else if (slot_end) begin
      slot_cnt  <= '0;
      col_idx   <= (col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1;
      col_out   <= col_drive((col_idx == 2'd2) ? 2'd0 : col_idx + 2'd1);
      frame_vec <= frame_end ? '0 : full_vec;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      db_cnt    <= '0;
      cand      <= '0;
      scan_data <= '0;
      valid     <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (frame_end) begin
        unique case (state)
          S_IDLE: if (cls == C_ONE) begin
            cand <= full_vec;
            if (DEBOUNCE_FRAMES == 1) begin
              scan_data <= full_vec;
              valid     <= 1'b1;
              key_held  <= 1'b1;
              db_cnt    <= '0;
              state     <= S_HELD;
            end else begin
              db_cnt <= DW'(1);
              state  <= S_PRESS_DB;
            end
          end
          S_PRESS_DB: if (full_vec == cand) begin
            if (db_cnt >= DB_LAST) begin
              scan_data <= cand;
              valid     <= 1'b1;
              key_held  <= 1'b1;
              db_cnt    <= '0;
              state     <= S_HELD;
            end else if (db_cnt != DB_MAX) begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
            state  <= S_IDLE;
          end
          // A different key while held is deliberately ignored: no repeat strobe.
          S_HELD: if (cls == C_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              key_held <= 1'b0;
              db_cnt   <= '0;
              state    <= S_IDLE;
            end else begin
              db_cnt <= DW'(1);
              state  <= S_REL_DB;
            end
          end
          S_REL_DB: if (cls == C_NONE) begin
            if (db_cnt >= DB_LAST) begin
              key_held <= 1'b0;
              db_cnt   <= '0;
              state    <= S_IDLE;
            end else if (db_cnt != DB_MAX) begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
            state  <= S_HELD;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: keypad matrix model, phase table, and a scoreboard of expected strobes.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DF = 3;
  localparam int FRAME = 3 * SD;
  localparam int LAT = DF * FRAME;

  logic            clk = 1'b0;
  logic            rst;
  logic [NROW-1:0] row_in;
  logic [NCOL-1:0] col_out;
  logic [NKEY-1:0] scan_data;
  logic            valid;
  logic            key_held;
  logic [NKEY-1:0] keys;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [NKEY-1:0] code;
    int              due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [NKEY-1:0] keys;
    int              frames;
    logic [NKEY-1:0] push_code;
    logic            exp_held;
    logic [NKEY-1:0] exp_data;
  } phase_t;
  phase_t phases[$];

  typedef struct {
    int              off;
    logic [NCOL-1:0] col;
  } col_t;
  col_t col_tab[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .scan_data (scan_data),
    .valid     (valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        if (keys[r*NCOL+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {20'h0, scan_data}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_code", {20'h0, scan_data}, {20'h0, e.code});
        chk("strobe_cycle", cyc, e.due);
      end
    end
  end

  task automatic flush_missed();
    while (sb.size() != 0 && sb[0].due < cyc) begin
      chk("missed_strobe", 32'h0, {20'h0, sb[0].code});
      void'(sb.pop_front());
    end
  endtask

  task automatic push_exp(input logic [NKEY-1:0] code);
    exp_t e;
    e.code = code;
    e.due  = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic add_phase(input logic [NKEY-1:0] k, input int f, input logic [NKEY-1:0] pc,
                           input logic h, input logic [NKEY-1:0] d);
    phase_t p;
    p.keys = k; p.frames = f; p.push_code = pc; p.exp_held = h; p.exp_data = d;
    phases.push_back(p);
  endtask

  initial begin
    add_phase(KEY_5, 6, KEY_5, 1'b1, KEY_5);
    add_phase('0,    2, '0,    1'b1, KEY_5);
    add_phase('0,    1, '0,    1'b0, KEY_5);
    for (int i = 0; i < 5; i++) begin
      add_phase(KEY_5, 1, '0, 1'b0, KEY_5);
      add_phase('0,    1, '0, 1'b0, KEY_5);
    end
    add_phase(KEY_STAR, 5, KEY_STAR, 1'b1, KEY_STAR);
    add_phase('0,       4, '0,       1'b0, KEY_STAR);
    add_phase(KEY_HASH, 5, KEY_HASH, 1'b1, KEY_HASH);
    add_phase(KEY_0,    2, '0,       1'b1, KEY_HASH);
    add_phase('0,       3, '0,       1'b0, KEY_HASH);
    add_phase(KEY_1 | KEY_9, 6, '0,  1'b0, KEY_HASH);
    add_phase(KEY_1,    5, KEY_1,    1'b1, KEY_1);
    add_phase('0,       3, '0,       1'b0, KEY_1);

    col_tab.push_back('{0, 3'b110});
    col_tab.push_back('{3, 3'b110});
    col_tab.push_back('{4, 3'b101});
    col_tab.push_back('{8, 3'b011});
    col_tab.push_back('{11, 3'b011});
    col_tab.push_back('{12, 3'b110});

    keys = '0;
    rst  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_col_out",   {29'h0, col_out},    32'h6);
    chk("rst_scan_data", {20'h0, scan_data},  32'h0);
    chk("rst_valid",     {31'h0, valid},      32'h0);
    chk("rst_key_held",  {31'h0, key_held},   32'h0);

    rst = 1'b1;
    begin
      int t = 0;
      foreach (col_tab[i]) begin
        while (t < col_tab[i].off) begin
          @(negedge clk);
          t++;
        end
        chk($sformatf("col_out_t%0d", t), {29'h0, col_out}, {29'h0, col_tab[i].col});
      end
    end
    chk("idle_scan_data", {20'h0, scan_data}, 32'h0);

    foreach (phases[i]) begin
      keys = phases[i].keys;
      if (phases[i].push_code != '0) push_exp(phases[i].push_code);
      repeat (phases[i].frames * FRAME) @(negedge clk);
      flush_missed();
      chk($sformatf("ph%0d_key_held", i), {31'h0, key_held}, {31'h0, phases[i].exp_held});
      chk($sformatf("ph%0d_scan_data", i), {20'h0, scan_data}, {20'h0, phases[i].exp_data});
    end

    // Reset in the middle of the press debounce of '4'.
    keys = KEY_4;
    repeat (FRAME + 5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_col_out",   {29'h0, col_out},   32'h6);
    chk("mid_rst_scan_data", {20'h0, scan_data}, 32'h0);
    chk("mid_rst_valid",     {31'h0, valid},     32'h0);
    chk("mid_rst_key_held",  {31'h0, key_held},  32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_exp(KEY_4);
    repeat (6 * FRAME) @(negedge clk);
    flush_missed();
    chk("post_rst_key_held",  {31'h0, key_held},  32'h1);
    chk("post_rst_scan_data", {20'h0, scan_data}, {20'h0, KEY_4});
    keys = '0;
    repeat (3 * FRAME) @(negedge clk);
    chk("post_rst_release", {31'h0, key_held}, 32'h0);

    repeat (2) @(negedge clk);
    flush_missed();
    chk("scoreboard_empty", sb.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
